// File: rtl/qlf_acc_pkg.sv
// Shared definitions for the accumulator stage.
//   - state_t / ST_*   : FSM state encoding (IDLE, ACCUM, OUT)
//   - cnt_width()      : bits needed to hold a sample count of 0..count
package qlf_acc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_OUT   = 2'd2;

  // Width of the accepted-sample counter for a batch of 'count' samples.
  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational add/subtract with carry/borrow out.
//   a    : accumulator operand (ACC_W bits)
//   b    : zero-extended sample operand (ACC_W bits)
//   sub  : 1 = a - b, 0 = a + b
//   sum  : result modulo 2^ACC_W
//   flag : carry out of an add, or borrow (a < b) of a subtract
module addsub_unit #(
  parameter int ACC_W = 6
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sub,
  output logic [ACC_W-1:0] sum,
  output logic             flag
);

  logic [ACC_W:0] ext;

  // One extra bit holds the carry on add; on subtract it goes high exactly
  // when the unsigned difference underflows, i.e. a < b.
  always_comb begin
    if (sub) begin
      ext = {1'b0, a} - {1'b0, b};
    end else begin
      ext = {1'b0, a} + {1'b0, b};
    end
    sum  = ext[ACC_W-1:0];
    flag = ext[ACC_W];
  end

endmodule

// File: rtl/accumulator_stage.sv
// Batch accumulator: sums COUNT accepted samples (each added or subtracted)
// and presents the result with a sticky carry/borrow flag.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : sample handshake; in_data unsigned, in_sub selects
//                         subtract
//   out_valid/out_ready : result handshake; out_data = accumulator,
//                         out_ovf = any carry/borrow during the batch
module accumulator_stage
  import qlf_acc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  parameter int ACC_W = WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = cnt_width(COUNT);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [ACC_W-1:0]   op_a;
  logic [ACC_W-1:0]   op_b;
  logic [ACC_W-1:0]   sum;
  logic               flag;

  assign in_ready  = (state_q != ST_OUT);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

  // The first sample of a batch starts from zero rather than the stale
  // result of the previous batch.
  assign op_a = (state_q == ST_IDLE) ? '0 : acc_q;
  assign op_b = {{(ACC_W-WIDTH){1'b0}}, in_data};

  addsub_unit #(
    .ACC_W (ACC_W)
  ) u_addsub (
    .a    (op_a),
    .b    (op_b),
    .sub  (in_sub),
    .sum  (sum),
    .flag (flag)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = sum;
          cnt_d   = CNT_W'(1);
          ovf_d   = flag;
          state_d = (COUNT == 1) ? ST_OUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | flag;
          // cnt_q counts samples before this one, so this is the last.
          if (cnt_q == CNT_W'(COUNT - 1)) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_accumulator_stage.sv
// Self-checking bench for accumulator_stage. Three builds share one stimulus:
//   0: defaults (COUNT=4, ACC_W=6), 1: ACC_W=5, 2: COUNT=1.
// A behavioural model tracks each build; every cycle the outputs are checked
// against it, plus literal expectations for the directed scenarios.
module tb_accumulator_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_sub = 1'b0;
  logic       out_ready = 1'b0;

  logic [2:0] in_ready_w;
  logic [2:0] out_valid_w;
  logic [2:0] out_ovf_w;
  logic [7:0] out_data_w [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int cfg_count(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int cfg_accw(input int i);
    return (i == 1) ? 5 : 6;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    localparam int C  = (gi == 2) ? 1 : 4;
    localparam int AW = (gi == 1) ? 5 : 6;
    logic [AW-1:0] od;

    accumulator_stage #(
      .WIDTH (4),
      .COUNT (C),
      .ACC_W (AW)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .out_data  (od),
      .out_ovf   (out_ovf_w[gi])
    );

    assign out_data_w[gi] = 8'(od);
  end

  // Behavioural model: plain integer arithmetic per build.
  int m_acc  [3] = '{0, 0, 0};
  int m_cnt  [3] = '{0, 0, 0};
  bit m_pend [3] = '{0, 0, 0};
  bit m_ovf  [3] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_acc[i]  <= 0;
        m_cnt[i]  <= 0;
        m_pend[i] <= 1'b0;
        m_ovf[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int modv, base, nv, nc;
        bit f;
        if (m_pend[i]) begin
          if (out_ready) m_pend[i] <= 1'b0;
        end else if (in_valid) begin
          modv = 1 << cfg_accw(i);
          base = (m_cnt[i] == 0) ? 0 : m_acc[i];
          nv   = in_sub ? base - int'(in_data) : base + int'(in_data);
          f    = (nv < 0) || (nv >= modv);
          m_acc[i] <= nv & (modv - 1);
          m_ovf[i] <= (m_cnt[i] == 0) ? f : (m_ovf[i] | f);
          nc = m_cnt[i] + 1;
          if (nc == cfg_count(i)) begin
            m_pend[i] <= 1'b1;
            m_cnt[i]  <= 0;
          end else begin
            m_cnt[i] <= nc;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic auto_check();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_valid[%0d]", i), int'(out_valid_w[i]), int'(m_pend[i]));
      chk($sformatf("model_ready[%0d]", i), int'(in_ready_w[i]), int'(!m_pend[i]));
      if (m_pend[i]) begin
        chk($sformatf("model_data[%0d]", i), int'(out_data_w[i]), m_acc[i]);
        chk($sformatf("model_ovf[%0d]", i), int'(out_ovf_w[i]), int'(m_ovf[i]));
      end
    end
  endtask

  // Advance one cycle; return at the following falling edge after checking.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    auto_check();
  endtask

  // Present one sample and hold it until build 0 accepts it.
  task automatic put(input bit sub, input int d);
    bit rdy;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_sub   = sub;
    in_data  = 4'(d);
    for (int k = 0; k < 50 && !done; k++) begin
      rdy = in_ready_w[0];
      tick();
      if (rdy) done = 1'b1;
    end
    if (!done) chk("put_timeout", 0, 1);
    $display("txn: sub=%0d data=%0d accepted=%0d", sub, d, done);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic result(input int i, input string name, input int d, input int o);
    chk({name, "_valid"}, int'(out_valid_w[i]), 1);
    chk({name, "_data"}, int'(out_data_w[i]), d);
    chk({name, "_ovf"}, int'(out_ovf_w[i]), o);
    $display("result[%0d] %s: data=%0d ovf=%0d", i, name, out_data_w[i], out_ovf_w[i]);
  endtask

  initial begin
    @(negedge clk);
    tick();
    chk("rst_valid", int'(out_valid_w[0]), 0);
    chk("rst_ready", int'(in_ready_w[0]), 1);
    chk("rst_data", int'(out_data_w[0]), 0);
    chk("rst_ovf", int'(out_ovf_w[0]), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", int'(out_valid_w[0]), 0);
    chk("post_rst_ready", int'(in_ready_w[0]), 1);

    // 3+5+7+9 back-to-back, then hold the result with out_ready low.
    out_ready = 1'b0;
    put(0, 3); put(0, 5); put(0, 7); put(0, 9);
    result(0, "sum24", 24, 0);
    in_data = 4'd7;
    for (int k = 0; k < 5; k++) begin
      tick();
      result(0, "hold", 24, 0);
      chk("hold_ready", int'(in_ready_w[0]), 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("release_valid", int'(out_valid_w[0]), 0);
    chk("release_ready", int'(in_ready_w[0]), 1);

    // Borrow on the first sample stays sticky.
    put(1, 1); put(0, 1); put(0, 1); put(0, 1);
    in_valid = 1'b0;
    result(0, "sticky", 2, 1);
    tick();

    // 15 x4: no carry in 6 bits, carry in 5 bits.
    put(0, 15); put(0, 15); put(0, 15); put(0, 15);
    in_valid = 1'b0;
    result(0, "w6_60", 60, 0);
    result(1, "w5_28", 28, 1);
    tick();

    // Reset mid-batch discards the partial sum.
    put(0, 5); put(0, 5);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valid", int'(out_valid_w[0]), 0);
    chk("midrst_ready", int'(in_ready_w[0]), 1);
    chk("midrst_data", int'(out_data_w[0]), 0);
    rst = 1'b0;
    tick();
    chk("after_rst_ready", int'(in_ready_w[0]), 1);
    put(0, 1); put(0, 1); put(0, 1); put(0, 1);
    in_valid = 1'b0;
    result(0, "fresh4", 4, 0);
    tick();

    // COUNT=1 build presents a single sample one cycle later.
    rst_pulse();
    put(0, 9);
    in_valid = 1'b0;
    result(2, "count1", 9, 0);
    tick();

    // in_valid every other cycle; idle cycles carry junk data.
    rst_pulse();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_sub = 1'b0; in_data = 4'(2 * k);
      tick();
      if (k < 4) begin
        in_valid = 1'b0; in_sub = 1'b1; in_data = 4'd15;
        tick();
      end
    end
    in_valid = 1'b0;
    result(0, "toggle20", 20, 0);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
